// File: rtl/if_fetch_queue.sv
// IF stage: PC generator plus a DEPTH-entry fetch queue with a valid/ready handshake to ID.
// Optional macro IF_PERF_CNT_EN adds redirect/starvation performance counters.
module if_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_req,
    output logic [WIDTH-1:0] fetch_addr,
    input  logic [ILEN-1:0]  fetch_rdata,
    input  logic [WIDTH-1:0] branch_predict_pc,
    input  logic             branch_taken,
    input  logic             branch_miss,
    input  logic [WIDTH-1:0] branch_miss_pc,
    input  logic             ctrl_flush,
    input  logic             ctrl_pc_re,
    input  logic [WIDTH-1:0] ctrl_next_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ILEN-1:0]  id_inst,
    output logic [WIDTH-1:0] id_pc,
    output logic             id_pred_taken,
    output logic             id_pc_re
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_redirect_cnt,
    output logic [31:0]      perf_starve_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic             r_pcre_pend;
    logic             r_inf_vld;
    logic [WIDTH-1:0] r_inf_pc;
    logic             r_inf_taken;
    logic             r_inf_pcre;

    logic [ILEN-1:0]  r_q_inst [DEPTH];
    logic [WIDTH-1:0] r_q_pc   [DEPTH];
    logic [DEPTH-1:0] r_q_taken;
    logic [DEPTH-1:0] r_q_pcre;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;

    logic             w_ctrl;
    logic             w_redirect;
    logic [AW:0]      w_occ;
    logic             w_push;
    logic             w_pop;

    assign w_ctrl     = ctrl_flush | ctrl_pc_re;
    assign w_redirect = w_ctrl | branch_miss;
    // Occupancy includes the in-flight fetch so a response always has a free slot.
    assign w_occ      = r_cnt + {{AW{1'b0}}, r_inf_vld};
    assign fetch_req  = !rst && !w_redirect && (w_occ < (AW+1)'(DEPTH));
    assign fetch_addr = r_pc;
    assign w_push     = r_inf_vld && !w_redirect;
    assign w_pop      = id_valid && id_ready && !w_redirect;

    assign id_valid      = (r_cnt != '0);
    assign id_inst       = r_q_inst[r_rd];
    assign id_pc         = r_q_pc[r_rd];
    assign id_pred_taken = r_q_taken[r_rd];
    assign id_pc_re      = r_q_pcre[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pcre_pend <= 1'b0;
            r_inf_vld   <= 1'b0;
            r_inf_pc    <= '0;
            r_inf_taken <= 1'b0;
            r_inf_pcre  <= 1'b0;
        end else begin
            r_inf_vld <= fetch_req;
            if (w_redirect) begin
                r_pc        <= w_ctrl ? ctrl_next_pc : branch_miss_pc;
                r_pcre_pend <= !w_ctrl;
            end else if (fetch_req) begin
                r_pc        <= branch_predict_pc;
                r_inf_pc    <= r_pc;
                r_inf_taken <= branch_taken;
                r_inf_pcre  <= r_pcre_pend;
                r_pcre_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
            r_q_taken <= '0;
            r_q_pcre  <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
        end else if (w_redirect) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_q_inst[r_wr]  <= fetch_rdata;
                r_q_pc[r_wr]    <= r_inf_pc;
                r_q_taken[r_wr] <= r_inf_taken;
                r_q_pcre[r_wr]  <= r_inf_pcre;
                r_wr            <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic w_starve;
    assign w_starve = id_ready && !id_valid && !w_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirect_cnt <= '0;
            perf_starve_cnt   <= '0;
        end else begin
            if (w_redirect && perf_redirect_cnt != '1)
                perf_redirect_cnt <= perf_redirect_cnt + 1'b1;
            if (w_starve && perf_starve_cnt != '1)
                perf_starve_cnt <= perf_starve_cnt + 1'b1;
        end
    end
`endif

endmodule
